alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one 16-bit ALU between two requesters. Each requester presents an ALU opcode and two operands over a valid/ready handshake. The block grants one request at a time, drives the ALU from registered operands, captures ALUResult/Zero, and returns a tagged one-cycle response. It sits between two issue sources (e.g. the main datapath and a helper unit) and the single ALU instance.

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational 16-bit ALU between two requesters.
// Each accepted op runs IDLE -> EXEC -> RESP and produces exactly one tagged response strobe.
module alu_arbiter #(
    parameter int n  = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [3:0]    req0_op,
    input  logic [n-1:0]  req0_a,
    input  logic [n-1:0]  req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [3:0]    req1_op,
    input  logic [n-1:0]  req1_a,
    input  logic [n-1:0]  req1_b,
    output logic [3:0]    alu_control,
    output logic [n-1:0]  alu_a,
    output logic [n-1:0]  alu_b,
    input  logic [n-1:0]  alu_result,
    input  logic          alu_zero,
    output logic          resp_valid,
    output logic          resp_id,
    output logic [n-1:0]  resp_result,
    output logic          resp_zero,
    output logic          busy,
    output logic [CW-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          r_lastGrant;
    logic          r_id;
    logic [3:0]    r_aluControl;
    logic [n-1:0]  r_aluA;
    logic [n-1:0]  r_aluB;
    logic          r_respId;
    logic [n-1:0]  r_respResult;
    logic          r_respZero;
    logic [CW-1:0] r_opCount;
    logic          w_grant;
    logic          w_grantValid;
    logic          w_accept;

    // Under contention the requester that did not win last time gets the grant.
    always_comb begin
        w_nextState  = r_state;
        w_grant      = 1'b0;
        w_grantValid = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_grant      = ~r_lastGrant;
                    w_grantValid = 1'b1;
                end else if (req0_valid) begin
                    w_grant      = 1'b0;
                    w_grantValid = 1'b1;
                end else if (req1_valid) begin
                    w_grant      = 1'b1;
                    w_grantValid = 1'b1;
                end
                if (w_grantValid) begin
                    w_nextState = EXEC;
                end
            end
            EXEC:    w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign w_accept   = w_grantValid && !reset;
    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept && w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A reset landing in EXEC or RESP simply discards the in-flight op and its count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastGrant  <= 1'b1;
            r_id         <= 1'b0;
            r_aluControl <= '0;
            r_aluA       <= '0;
            r_aluB       <= '0;
            r_respId     <= 1'b0;
            r_respResult <= '0;
            r_respZero   <= 1'b0;
            r_opCount    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_grant) begin
                            r_aluControl <= req1_op;
                            r_aluA       <= req1_a;
                            r_aluB       <= req1_b;
                        end else begin
                            r_aluControl <= req0_op;
                            r_aluA       <= req0_a;
                            r_aluB       <= req0_b;
                        end
                        r_id        <= w_grant;
                        r_lastGrant <= w_grant;
                    end
                end
                EXEC: begin
                    r_respResult <= alu_result;
                    r_respZero   <= alu_zero;
                    r_respId     <= r_id;
                end
                RESP:    r_opCount <= r_opCount + CW'(1);
                default: ;
            endcase
        end
    end

    assign alu_control = r_aluControl;
    assign alu_a       = r_aluA;
    assign alu_b       = r_aluB;
    assign resp_valid  = (r_state == RESP) && !reset;
    assign resp_id     = r_respId;
    assign resp_result = r_respResult;
    assign resp_zero   = r_respZero;
    assign busy        = (r_state != IDLE);
    assign op_count    = r_opCount;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU (0 AND, 1 OR, 2 ADD, 4 XOR, 6 SUB).
// Counter width is 4 so the wrap case stays short.
module tb_alu_arbiter;

    localparam int N  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [3:0]    req0_op, req1_op;
    logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]    alu_control;
    logic [N-1:0]  alu_a, alu_b;
    logic [N-1:0]  aluResult;
    logic          aluZero;
    logic          resp_valid, resp_id, resp_zero, busy;
    logic [N-1:0]  resp_result;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.n(N), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(aluResult), .alu_zero(aluZero),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_zero(resp_zero), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_control)
            4'd0:    aluResult = alu_a & alu_b;
            4'd1:    aluResult = alu_a | alu_b;
            4'd2:    aluResult = alu_a + alu_b;
            4'd4:    aluResult = alu_a ^ alu_b;
            4'd6:    aluResult = alu_a - alu_b;
            default: aluResult = '0;
        endcase
        aluZero = (aluResult == '0);
    end

    // Issues one op from requester k; returns accept status and the observed response.
    task automatic applyStimulus(input bit k, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                 output bit ok, output int lat, output logic id,
                                 output logic [N-1:0] res, output logic zero);
        bit accepted;
        accepted = 1'b0;
        ok = 1'b0;
        lat = -1;
        id = 1'b0;
        res = '0;
        zero = 1'b0;
        if (k) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < 8 && !accepted; i++) begin
            @(negedge clk);
            if (k ? req1_ready : req0_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        if (k) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
        if (accepted) begin
            for (int i = 1; i <= 6; i++) begin
                @(posedge clk); #1;
                if (resp_valid) begin
                    lat = i; id = resp_id; res = resp_result; zero = resp_zero;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        ok = accepted && (lat > 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'h0001; req0_b = 16'h0001;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 16'h0002; req1_b = 16'h0002;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ready: got %b%b, want 00", req0_ready, req1_ready);
        end
        checks++;
        if ({busy, resp_valid, resp_id, resp_zero} !== 4'b0000 || op_count !== 4'h0 || resp_result !== 16'h0) begin
            errors++; $display("[TB] FAIL reset_status: got busy=%b rv=%b id=%b z=%b cnt=%h res=%h, want all zero",
                               busy, resp_valid, resp_id, resp_zero, op_count, resp_result);
        end
        checks++;
        if (alu_control !== 4'h0 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
            errors++; $display("[TB] FAIL reset_alu: got ctl=%h a=%h b=%h, want 0 0 0", alu_control, alu_a, alu_b);
        end
        @(posedge clk); #1;
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single_add();
        bit ok; int lat; logic id; logic [N-1:0] res; logic zero;
        applyStimulus(1'b0, 4'd2, 16'h1000, 16'h2000, ok, lat, id, res, zero);
        checks++;
        if (!ok || lat != 1) begin
            errors++; $display("[TB] FAIL add_latency: got ok=%b edges=%0d, want ok=1 edges=1", ok, lat);
        end
        checks++;
        if (id !== 1'b0 || res !== 16'h3000 || zero !== 1'b0) begin
            errors++; $display("[TB] FAIL add_resp: got id=%b res=%h z=%b, want 0 3000 0", id, res, zero);
        end
        checks++;
        if (op_count !== 4'h1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL add_after: got cnt=%h busy=%b rv=%b, want 1 0 0", op_count, busy, resp_valid);
        end
        checks++;
        if (alu_control !== 4'd2 || alu_a !== 16'h1000 || alu_b !== 16'h2000 || resp_result !== 16'h3000) begin
            errors++; $display("[TB] FAIL add_hold: got ctl=%h a=%h b=%h res=%h, want 2 1000 2000 3000",
                               alu_control, alu_a, alu_b, resp_result);
        end
    endtask

    task automatic test_zero_flag();
        bit ok; int lat; logic id; logic [N-1:0] res; logic zero;
        applyStimulus(1'b1, 4'd0, 16'hAAAA, 16'h5555, ok, lat, id, res, zero);
        checks++;
        if (!ok || id !== 1'b1 || res !== 16'h0000 || zero !== 1'b1) begin
            errors++; $display("[TB] FAIL zero_and: got ok=%b id=%b res=%h z=%b, want 1 1 0000 1", ok, id, res, zero);
        end
        applyStimulus(1'b1, 4'd6, 16'h2000, 16'h1000, ok, lat, id, res, zero);
        checks++;
        if (!ok || id !== 1'b1 || res !== 16'h1000 || zero !== 1'b0) begin
            errors++; $display("[TB] FAIL zero_sub: got ok=%b id=%b res=%h z=%b, want 1 1 1000 0", ok, id, res, zero);
        end
        checks++;
        if (op_count !== 4'h3) begin
            errors++; $display("[TB] FAIL zero_count: got %h, want 3", op_count);
        end
    endtask

    task automatic test_contention();
        int nAcc, nResp, bothReady;
        int accCycle[4];
        logic accId[4];
        logic respIdSeen[4];
        logic [N-1:0] respRes[4];
        logic [N-1:0] expRes[4];
        logic expId[4];
        expRes = '{16'h567C, 16'hFFFF, 16'h567C, 16'hFFFF};
        expId  = '{1'b0, 1'b1, 1'b0, 1'b1};
        nAcc = 0; nResp = 0; bothReady = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 16'h1234; req0_b = 16'h5678;
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = 16'hF0F0; req1_b = 16'h0F0F;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) bothReady++;
            if ((req0_ready || req1_ready) && nAcc < 4) begin
                accCycle[nAcc] = c; accId[nAcc] = req1_ready; nAcc++;
            end
            if (resp_valid && nResp < 4) begin
                respIdSeen[nResp] = resp_id; respRes[nResp] = resp_result; nResp++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (nAcc != 4 || nResp != 4 || bothReady != 0) begin
            errors++; $display("[TB] FAIL contention_counts: got acc=%0d resp=%0d both=%0d, want 4 4 0", nAcc, nResp, bothReady);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < nAcc) begin
                checks++;
                if (accId[i] !== expId[i] || accCycle[i] != 3 * i) begin
                    errors++; $display("[TB] FAIL contention_accept%0d: got id=%b cycle=%0d, want id=%b cycle=%0d",
                                       i, accId[i], accCycle[i], expId[i], 3 * i);
                end
            end
            if (i < nResp) begin
                checks++;
                if (respIdSeen[i] !== expId[i] || respRes[i] !== expRes[i]) begin
                    errors++; $display("[TB] FAIL contention_resp%0d: got id=%b res=%h, want id=%b res=%h",
                                       i, respIdSeen[i], respRes[i], expId[i], expRes[i]);
                end
            end
        end
        checks++;
        if (op_count !== 4'h4) begin
            errors++; $display("[TB] FAIL contention_count: got %h, want 4", op_count);
        end
    endtask

    task automatic test_handshake_hold();
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'h0005; req0_b = 16'h0006;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_req0_ready: got %b, want 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd6; req1_a = 16'h0009; req1_b = 16'h0004;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_exec: got ready=%b busy=%b, want 0 1", req1_ready, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b0 || resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_result !== 16'h000B) begin
            errors++; $display("[TB] FAIL hold_resp: got ready=%b rv=%b id=%b res=%h, want 0 1 0 000b",
                               req1_ready, resp_valid, resp_id, resp_result);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_idle_ready: got %b, want 1", req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        checks++;
        if (alu_control !== 4'd6 || alu_a !== 16'h0009 || alu_b !== 16'h0004) begin
            errors++; $display("[TB] FAIL hold_payload: got ctl=%h a=%h b=%h, want 6 0009 0004", alu_control, alu_a, alu_b);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_result !== 16'h0005) begin
            errors++; $display("[TB] FAIL hold_req1_resp: got rv=%b id=%b res=%h, want 1 1 0005", resp_valid, resp_id, resp_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        bit ok; int lat; logic id; logic [N-1:0] res; logic zero;
        int seen;
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'h0001; req0_b = 16'h0001;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_exec: got busy=%b, want 1", busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({busy, resp_valid, resp_id, resp_zero} !== 4'b0000 || op_count !== 4'h0 || resp_result !== 16'h0 ||
            alu_control !== 4'h0 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
            errors++; $display("[TB] FAIL midreset_state: got busy=%b rv=%b cnt=%h res=%h ctl=%h a=%h b=%h, want all zero",
                               busy, resp_valid, op_count, resp_result, alu_control, alu_a, alu_b);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("[TB] FAIL midreset_no_resp: got %0d strobes, want 0", seen);
        end
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = 16'h00FF; req1_b = 16'h0F0F;
        applyStimulus(1'b0, 4'd1, 16'h00F0, 16'h000F, ok, lat, id, res, zero);
        req1_valid = 1'b0;
        checks++;
        if (!ok || id !== 1'b0 || res !== 16'h00FF || op_count !== 4'h1) begin
            errors++; $display("[TB] FAIL midreset_next: got ok=%b id=%b res=%h cnt=%h, want 1 0 00ff 1", ok, id, res, op_count);
        end
    endtask

    task automatic test_counter_wrap();
        bit ok; int lat; logic id; logic [N-1:0] res; logic zero;
        int bad;
        bad = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(i[0], 4'd2, 16'(i), 16'h0100, ok, lat, id, res, zero);
            if (!ok || res !== 16'(i + 256)) bad++;
            if (i == 15) begin
                checks++;
                if (op_count !== 4'hF) begin
                    errors++; $display("[TB] FAIL wrap_15: got %h, want f", op_count);
                end
            end
            if (i == 16) begin
                checks++;
                if (op_count !== 4'h0) begin
                    errors++; $display("[TB] FAIL wrap_16: got %h, want 0", op_count);
                end
            end
        end
        checks++;
        if (op_count !== 4'h1 || bad != 0) begin
            errors++; $display("[TB] FAIL wrap_17: got cnt=%h bad_ops=%0d, want 1 0", op_count, bad);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        test_reset();
        test_single_add();
        test_zero_flag();
        test_contention();
        test_handshake_hold();
        test_reset_mid_op();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
